// File: rtl/tlb_page_splitter.sv
// Splits parsed requests so that no emitted piece crosses a page boundary.
// Optional huge-page boundary selection is enabled with `define TLB_SPLIT_HUGE_EN.
module tlb_page_splitter #(
    parameter int PG_BITS    = 12,
    parameter int HPG_BITS   = 21,
    parameter int VADDR_BITS = 48,
    parameter int LEN_BITS   = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_in_valid,
    output logic                  req_in_ready,
    input  logic [VADDR_BITS-1:0] req_in_vaddr,
    input  logic [LEN_BITS-1:0]   req_in_len,
    input  logic                  req_in_ctl,
    input  logic                  req_in_sync,
    input  logic                  req_in_stream,
    input  logic [3:0]            req_in_dest,
    input  logic [1:0]            req_in_cache_mode,
    input  logic                  req_in_rsrvd,
    input  logic                  req_in_rsrvd_high,
`ifdef TLB_SPLIT_HUGE_EN
    input  logic                  hpage_in,
    output logic                  hpage_out,
`endif
    output logic                  req_out_valid,
    input  logic                  req_out_ready,
    output logic [VADDR_BITS-1:0] req_out_vaddr,
    output logic [LEN_BITS-1:0]   req_out_len,
    output logic                  req_out_ctl,
    output logic                  req_out_sync,
    output logic                  req_out_stream,
    output logic [3:0]            req_out_dest,
    output logic [1:0]            req_out_cache_mode,
    output logic                  req_out_rsrvd,
    output logic                  req_out_rsrvd_high
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam logic [LEN_BITS-1:0] SMALL_PG = LEN_BITS'(1) << PG_BITS;
    localparam logic [LEN_BITS-1:0] HUGE_PG  = LEN_BITS'(1) << HPG_BITS;

    state_t                r_state,     w_nxt_state;
    logic [VADDR_BITS-1:0] r_vaddr,     w_nxt_vaddr;
    logic [LEN_BITS-1:0]   r_len,       w_nxt_len;
    logic                  r_ctl,       w_nxt_ctl;
    logic                  r_sync,      w_nxt_sync;
    logic                  r_stream,    w_nxt_stream;
    logic [3:0]            r_dest,      w_nxt_dest;
    logic [1:0]            r_cmode,     w_nxt_cmode;
    logic                  r_hpage,     w_nxt_hpage;
    logic [VADDR_BITS-1:0] r_out_vaddr, w_nxt_out_vaddr;
    logic [LEN_BITS-1:0]   r_out_len,   w_nxt_out_len;
    logic                  r_out_ctl,   w_nxt_out_ctl;

    logic [LEN_BITS-1:0]   w_pg_size;
    logic [LEN_BITS-1:0]   w_off;
    logic [LEN_BITS-1:0]   w_rem;
    logic                  w_hpage_src;
    logic                  w_unused;

`ifdef TLB_SPLIT_HUGE_EN
    assign w_hpage_src = hpage_in;
    assign w_pg_size   = r_hpage ? HUGE_PG : SMALL_PG;
    assign hpage_out   = r_hpage;
`else
    assign w_hpage_src = 1'b0;
    assign w_pg_size   = SMALL_PG;
`endif

    // Bytes left to the next boundary; an aligned address yields a full page.
    assign w_off = LEN_BITS'(r_vaddr) & (w_pg_size - LEN_BITS'(1));
    assign w_rem = w_pg_size - w_off;

    assign w_unused = ^{req_in_rsrvd, req_in_rsrvd_high, HPG_BITS[0]};

    assign req_in_ready       = (r_state == ST_IDLE);
    assign req_out_valid      = (r_state == ST_SEND);
    assign req_out_vaddr      = r_out_vaddr;
    assign req_out_len        = r_out_len;
    assign req_out_ctl        = r_out_ctl;
    assign req_out_sync       = r_sync;
    assign req_out_stream     = r_stream;
    assign req_out_dest       = r_dest;
    assign req_out_cache_mode = r_cmode;
    assign req_out_rsrvd      = 1'b0;
    assign req_out_rsrvd_high = 1'b0;

    // Next-state and datapath update for the accept/split/send loop.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_vaddr     = r_vaddr;
        w_nxt_len       = r_len;
        w_nxt_ctl       = r_ctl;
        w_nxt_sync      = r_sync;
        w_nxt_stream    = r_stream;
        w_nxt_dest      = r_dest;
        w_nxt_cmode     = r_cmode;
        w_nxt_hpage     = r_hpage;
        w_nxt_out_vaddr = r_out_vaddr;
        w_nxt_out_len   = r_out_len;
        w_nxt_out_ctl   = r_out_ctl;
        case (r_state)
            ST_IDLE: begin
                if (req_in_valid) begin
                    w_nxt_vaddr  = req_in_vaddr;
                    w_nxt_len    = req_in_len;
                    w_nxt_ctl    = req_in_ctl;
                    w_nxt_sync   = req_in_sync;
                    w_nxt_stream = req_in_stream;
                    w_nxt_dest   = req_in_dest;
                    w_nxt_cmode  = req_in_cache_mode;
                    w_nxt_hpage  = w_hpage_src;
                    w_nxt_state  = ST_SPLIT;
                end else begin
                    w_nxt_state  = ST_IDLE;
                end
            end
            ST_SPLIT: begin
                w_nxt_out_vaddr = r_vaddr;
                if (r_len > w_rem) begin
                    w_nxt_out_len = w_rem;
                    w_nxt_out_ctl = 1'b0;
                    w_nxt_vaddr   = r_vaddr + VADDR_BITS'(w_rem);
                    w_nxt_len     = r_len - w_rem;
                end else begin
                    w_nxt_out_len = r_len;
                    w_nxt_out_ctl = r_ctl;
                    w_nxt_len     = '0;
                end
                w_nxt_state = ST_SEND;
            end
            ST_SEND: begin
                if (req_out_ready) begin
                    w_nxt_state = (r_len != '0) ? ST_SPLIT : ST_IDLE;
                end else begin
                    w_nxt_state = ST_SEND;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_vaddr     <= '0;
            r_len       <= '0;
            r_ctl       <= 1'b0;
            r_sync      <= 1'b0;
            r_stream    <= 1'b0;
            r_dest      <= 4'd0;
            r_cmode     <= 2'd0;
            r_hpage     <= 1'b0;
            r_out_vaddr <= '0;
            r_out_len   <= '0;
            r_out_ctl   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_vaddr     <= w_nxt_vaddr;
            r_len       <= w_nxt_len;
            r_ctl       <= w_nxt_ctl;
            r_sync      <= w_nxt_sync;
            r_stream    <= w_nxt_stream;
            r_dest      <= w_nxt_dest;
            r_cmode     <= w_nxt_cmode;
            r_hpage     <= w_nxt_hpage;
            r_out_vaddr <= w_nxt_out_vaddr;
            r_out_len   <= w_nxt_out_len;
            r_out_ctl   <= w_nxt_out_ctl;
        end
    end

endmodule
